// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the windowed multiply-accumulate blocks:
//   - default operand width and fixed-point position
//   - accumulator width helper (sized so a full window can never overflow)
//   - FSM state encoding shared by the sequential MAC
//   - saturation bounds for a DATA_SIZE two's-complement result
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_FRAC_BITS = 6;

    // Default saturation bounds for 8-bit results
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product width plus enough guard bits for KERNEL_SIZE additions and sign
    function automatic int acc_w(input int dataSize, input int kernelSize);
        return 2 * dataSize + $clog2(kernelSize) + 1;
    endfunction

    function automatic int sat_max(input int dataSize);
        return (2 ** (dataSize - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dataSize);
        return -(2 ** (dataSize - 1));
    endfunction

endpackage

// File: rtl/mac_window_seq_if.sv
// ---------------------------------------------------------------------------
// mac_window_seq_if
// Window-in / result-out handshake bundle for mac_window_seq.
//   in_valid/in_ready   : window operand handshake
//   in_data/in_weight   : KERNEL_SIZE packed elements, element 0 in MS slice
//   in_bias, relu_en    : per-window bias and ReLU enable
//   out_valid/out_ready : result handshake
//   out_data, out_sat   : result and saturation flag
// master = producer/consumer side (window generator + writer), slave = MAC.
// ---------------------------------------------------------------------------
interface mac_window_seq_if #(
    parameter int DATA_SIZE   = 8,
    parameter int KERNEL_SIZE = 9
);
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_SIZE*KERNEL_SIZE-1:0]  in_data;
    logic [DATA_SIZE*KERNEL_SIZE-1:0]  in_weight;
    logic [DATA_SIZE-1:0]              in_bias;
    logic                              relu_en;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_SIZE-1:0]              out_data;
    logic                              out_sat;

    modport master (
        output in_valid, in_data, in_weight, in_bias, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_weight, in_bias, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_round_sat.sv
// ---------------------------------------------------------------------------
// mac_round_sat
// Combinational post-accumulation stage: bias add, round half-up, saturate
// and optional ReLU. Shared between the conv MAC and the FC layer.
//   i_acc     : signed accumulator, 2*FRAC_BITS fractional bits
//   i_bias    : signed bias, FRAC_BITS fractional bits
//   i_reluEn  : clamp negative results to zero
//   o_data    : DATA_SIZE result, FRAC_BITS fractional bits
//   o_sat     : result was clipped to the representable range
// ---------------------------------------------------------------------------
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = 21
) (
    input  logic signed [ACC_W-1:0]     i_acc,
    input  logic signed [DATA_SIZE-1:0] i_bias,
    input  logic                        i_reluEn,
    output logic [DATA_SIZE-1:0]        o_data,
    output logic                        o_sat
);

    // One spare bit so bias and rounding constant can never wrap the sum
    localparam int SUM_W = ACC_W + 1;
    // Half an output LSB; evaluates to zero when FRAC_BITS is 0
    localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'((1 << FRAC_BITS) >> 1);
    localparam logic signed [SUM_W-1:0] MAX_C   = SUM_W'(sat_max(DATA_SIZE));
    localparam logic signed [SUM_W-1:0] MIN_C   = SUM_W'(sat_min(DATA_SIZE));

    logic signed [SUM_W-1:0] w_biasExt;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shifted;

    // Bias is aligned to the product's 2*FRAC_BITS fractional position
    assign w_biasExt = SUM_W'(i_bias) <<< FRAC_BITS;
    assign w_sum     = SUM_W'(i_acc) + w_biasExt + ROUND_C;
    assign w_shifted = w_sum >>> FRAC_BITS;

    // Clip to range first; ReLU then acts on the clipped value and leaves
    // the saturation flag as it was
    always_comb begin
        o_sat  = 1'b0;
        o_data = w_shifted[DATA_SIZE-1:0];
        if (w_shifted > MAX_C) begin
            o_data = MAX_C[DATA_SIZE-1:0];
            o_sat  = 1'b1;
        end else if (w_shifted < MIN_C) begin
            o_data = MIN_C[DATA_SIZE-1:0];
            o_sat  = 1'b1;
        end
        if (i_reluEn && o_data[DATA_SIZE-1]) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/mac_window_seq.sv
// ---------------------------------------------------------------------------
// mac_window_seq
// Sequential window multiply-accumulate for the conv datapath. Accepts one
// KERNEL_SIZE window per handshake, accumulates LANES products per cycle,
// then bias-adds, rounds, saturates and optionally applies ReLU.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mac_window_seq_if slave (window in, result out)
// Latency from accept edge to out_valid: KERNEL_SIZE/LANES + 1 cycles.
// ---------------------------------------------------------------------------
module mac_window_seq
    import mac_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int KERNEL_SIZE = 9,
    parameter int LANES       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_window_seq_if.slave bus
);

    localparam int ACC_W  = acc_w(DATA_SIZE, KERNEL_SIZE);
    localparam int PROD_W = 2 * DATA_SIZE;
    localparam int VEC_W  = DATA_SIZE * KERNEL_SIZE;
    localparam int STEP   = DATA_SIZE * LANES;
    localparam int GROUPS = KERNEL_SIZE / LANES;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_MAC   = MAC;
    localparam logic [1:0] S_FINAL = FINAL;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]                 r_state;
    logic [VEC_W-1:0]           r_data;
    logic [VEC_W-1:0]           r_weight;
    logic signed [DATA_SIZE-1:0] r_bias;
    logic                       r_relu;
    logic signed [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]           r_idx;
    logic [DATA_SIZE-1:0]       r_outData;
    logic                       r_outSat;
    logic                       r_outValid;

    logic signed [ACC_W-1:0]    w_laneSum;
    logic [DATA_SIZE-1:0]       w_rsData;
    logic                       w_rsSat;

    // The operand registers shift left by one group each MAC cycle, so the
    // current group always sits in the top LANES slices and no variable
    // indexing is needed.
    always_comb begin
        w_laneSum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_laneSum = w_laneSum + ACC_W'(
                PROD_W'($signed(r_data[VEC_W-1-l*DATA_SIZE -: DATA_SIZE])) *
                PROD_W'($signed(r_weight[VEC_W-1-l*DATA_SIZE -: DATA_SIZE])));
        end
    end

    mac_round_sat #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_roundSat (
        .i_acc    (r_acc),
        .i_bias   (r_bias),
        .i_reluEn (r_relu),
        .o_data   (w_rsData),
        .o_sat    (w_rsSat)
    );

    // Window FSM: capture operands, step through the groups, register the
    // finished result and hold it until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_weight   <= '0;
            r_bias     <= '0;
            r_relu     <= 1'b0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_outData  <= '0;
            r_outSat   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_data   <= bus.in_data;
                        r_weight <= bus.in_weight;
                        r_bias   <= bus.in_bias;
                        r_relu   <= bus.relu_en;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc    <= r_acc + w_laneSum;
                    r_data   <= r_data << STEP;
                    r_weight <= r_weight << STEP;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(GROUPS - 1)) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_outData  <= w_rsData;
                    r_outSat   <= w_rsSat;
                    r_outValid <= 1'b1;
                    r_state    <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_sat   = r_outSat;

endmodule

// File: tb/tb_mac_window_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_window_seq
// Self-checking bench for mac_window_seq. Two instances share clock and
// reset: dut1 with LANES=1 (default) and dut3 with LANES=3. Expected results
// come from a plain integer fixed-point model of the window arithmetic.
// ---------------------------------------------------------------------------
module tb_mac_window_seq;

    localparam int DS = 8;
    localparam int FB = 6;
    localparam int KS = 9;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mac_window_seq_if #(.DATA_SIZE(DS), .KERNEL_SIZE(KS)) bus1 ();
    mac_window_seq_if #(.DATA_SIZE(DS), .KERNEL_SIZE(KS)) bus3 ();

    mac_window_seq #(.DATA_SIZE(DS), .FRAC_BITS(FB), .KERNEL_SIZE(KS), .LANES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mac_window_seq #(.DATA_SIZE(DS), .FRAC_BITS(FB), .KERNEL_SIZE(KS), .LANES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int passCnt  = 0;
    int totalCnt = 0;

    int curD[KS];
    int curW[KS];
    int curB;

    // Element 0 goes into the most significant slice
    function automatic logic [DS*KS-1:0] packArr(input int a[KS]);
        logic [DS*KS-1:0] v;
        v = '0;
        for (int k = 0; k < KS; k++) v[(KS-1-k)*DS +: DS] = DS'(a[k]);
        return v;
    endfunction

    // Real-valued meaning: sum(d*w)/2^12 + b/2^6, rounded half-up to 2^-6,
    // clipped to 8-bit signed, optional ReLU. Returns {sat, data}.
    function automatic logic [DS:0] model(input int relu);
        int sum;
        int res;
        logic sat;
        sum = 0;
        for (int k = 0; k < KS; k++) sum += curD[k] * curW[k];
        sum += curB * (1 << FB);
        sum += (1 << FB) / 2;
        res = sum >>> FB;
        sat = 1'b0;
        if (res > 127) begin
            res = 127;
            sat = 1'b1;
        end else if (res < -128) begin
            res = -128;
            sat = 1'b1;
        end
        if (relu != 0 && res < 0) res = 0;
        return {sat, DS'(res)};
    endfunction

    task automatic clearOps();
        for (int k = 0; k < KS; k++) begin
            curD[k] = 0;
            curW[k] = 0;
        end
        curB = 0;
    endtask

    task automatic randomOps();
        for (int k = 0; k < KS; k++) begin
            curD[k] = int'($urandom_range(255)) - 128;
            curW[k] = int'($urandom_range(255)) - 128;
        end
        curB = int'($urandom_range(255)) - 128;
    endtask

    // Drives one window into dut1 and waits for its result; lat=-1 on timeout
    task automatic runWindow1(input int relu, output logic [DS-1:0] data,
                              output logic sat, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus1.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus1.in_data   = packArr(curD);
        bus1.in_weight = packArr(curW);
        bus1.in_bias   = DS'(curB);
        bus1.relu_en   = (relu != 0);
        bus1.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = {8'($urandom), 32'($urandom), 32'($urandom)};
        bus1.in_weight = {8'($urandom), 32'($urandom), 32'($urandom)};
        bus1.in_bias   = 8'($urandom);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus1.out_valid) begin
                lat = c;
                break;
            end
        end
        data = bus1.out_data;
        sat  = bus1.out_sat;
    endtask

    task automatic releaseOut1();
        @(negedge clk);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        totalCnt++;
        if (bus1.in_ready !== 1'b1) $display("[TB] FAIL reset.in_ready: got %b expected 1", bus1.in_ready);
        else passCnt++;
        totalCnt++;
        if (bus1.out_valid !== 1'b0) $display("[TB] FAIL reset.out_valid: got %b expected 0", bus1.out_valid);
        else passCnt++;
        totalCnt++;
        if (bus1.out_data !== 8'h00) $display("[TB] FAIL reset.out_data: got %h expected 00", bus1.out_data);
        else passCnt++;
        totalCnt++;
        if (bus1.out_sat !== 1'b0) $display("[TB] FAIL reset.out_sat: got %b expected 0", bus1.out_sat);
        else passCnt++;
        totalCnt++;
        if (bus3.in_ready !== 1'b1) $display("[TB] FAIL reset.in_ready3: got %b expected 1", bus3.in_ready);
        else passCnt++;
    endtask

    task automatic test_single();
        logic [DS:0] exp;
        logic [DS-1:0] d;
        logic s;
        int lat;
        clearOps();
        curD[0] = 64;
        curW[0] = 32;
        curB    = 16;
        exp = model(0);
        runWindow1(0, d, s, lat);
        totalCnt++;
        if (d !== exp[DS-1:0]) $display("[TB] FAIL single.data: got %0d expected %0d", $signed(d), $signed(exp[DS-1:0]));
        else passCnt++;
        totalCnt++;
        if (s !== exp[DS]) $display("[TB] FAIL single.sat: got %b expected %b", s, exp[DS]);
        else passCnt++;
        totalCnt++;
        if (lat != 10) $display("[TB] FAIL single.latency: got %0d expected 10", lat);
        else passCnt++;
        releaseOut1();
    endtask

    task automatic test_negative();
        logic [DS:0] exp;
        logic [DS-1:0] d;
        logic s;
        int lat;
        clearOps();
        curD[0] = -64;
        curW[0] = 32;
        for (int relu = 0; relu < 2; relu++) begin
            exp = model(relu);
            runWindow1(relu, d, s, lat);
            totalCnt++;
            if (d !== exp[DS-1:0] || s !== exp[DS])
                $display("[TB] FAIL negative.relu%0d: got %0d/%b expected %0d/%b", relu, $signed(d), s, $signed(exp[DS-1:0]), exp[DS]);
            else passCnt++;
            releaseOut1();
        end
    endtask

    task automatic test_round_sat();
        logic [DS:0] exp;
        logic [DS-1:0] d;
        logic s;
        int lat;
        for (int t = 0; t < 3; t++) begin
            clearOps();
            if (t == 0) begin
                curD[0] = 1;
                curW[0] = 32;
            end else begin
                for (int k = 0; k < KS; k++) begin
                    curD[k] = 64;
                    curW[k] = (t == 1) ? 64 : -64;
                end
            end
            exp = model(0);
            runWindow1(0, d, s, lat);
            totalCnt++;
            if (d !== exp[DS-1:0] || s !== exp[DS])
                $display("[TB] FAIL round_sat.case%0d: got %0d/%b expected %0d/%b", t, $signed(d), s, $signed(exp[DS-1:0]), exp[DS]);
            else passCnt++;
            releaseOut1();
        end
    endtask

    task automatic test_random();
        logic [DS:0] exp;
        logic [DS-1:0] d;
        logic s;
        int lat;
        int relu;
        for (int t = 0; t < 12; t++) begin
            randomOps();
            relu = int'($urandom_range(1));
            exp = model(relu);
            runWindow1(relu, d, s, lat);
            totalCnt++;
            if (d !== exp[DS-1:0] || s !== exp[DS] || lat != 10)
                $display("[TB] FAIL random.win%0d: got %0d/%b lat %0d expected %0d/%b lat 10", t, $signed(d), s, lat, $signed(exp[DS-1:0]), exp[DS]);
            else passCnt++;
            releaseOut1();
        end
    endtask

    task automatic test_backpressure();
        logic [DS:0] expA;
        logic [DS:0] expB;
        logic [DS-1:0] d;
        logic s;
        int lat;
        randomOps();
        expA = model(0);
        runWindow1(0, d, s, lat);
        totalCnt++;
        if (d !== expA[DS-1:0] || s !== expA[DS])
            $display("[TB] FAIL backpressure.first: got %0d/%b expected %0d/%b", $signed(d), s, $signed(expA[DS-1:0]), expA[DS]);
        else passCnt++;
        // New window offered while the result is still pending
        @(negedge clk);
        randomOps();
        expB = model(1);
        bus1.in_data   = packArr(curD);
        bus1.in_weight = packArr(curW);
        bus1.in_bias   = DS'(curB);
        bus1.relu_en   = 1'b1;
        bus1.in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            totalCnt++;
            if (bus1.out_valid !== 1'b1 || bus1.out_data !== expA[DS-1:0] || bus1.out_sat !== expA[DS] || bus1.in_ready !== 1'b0)
                $display("[TB] FAIL backpressure.hold%0d: got v%b d%0d s%b r%b expected v1 d%0d s%b r0", c,
                         bus1.out_valid, $signed(bus1.out_data), bus1.out_sat, bus1.in_ready, $signed(expA[DS-1:0]), expA[DS]);
            else passCnt++;
        end
        @(negedge clk);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        totalCnt++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
            $display("[TB] FAIL backpressure.release: got v%b r%b expected v0 r1", bus1.out_valid, bus1.in_ready);
        else passCnt++;
        // in_valid is still high, so window B is taken on the next edge
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus1.out_valid) begin
                lat = c;
                break;
            end
        end
        totalCnt++;
        if (bus1.out_data !== expB[DS-1:0] || bus1.out_sat !== expB[DS] || lat != 10)
            $display("[TB] FAIL backpressure.second: got %0d/%b lat %0d expected %0d/%b lat 10",
                     $signed(bus1.out_data), bus1.out_sat, lat, $signed(expB[DS-1:0]), expB[DS]);
        else passCnt++;
        releaseOut1();
    endtask

    task automatic test_reset_mid();
        logic [DS:0] exp;
        logic [DS-1:0] d;
        logic s;
        int lat;
        randomOps();
        @(negedge clk);
        bus1.in_data   = packArr(curD);
        bus1.in_weight = packArr(curW);
        bus1.in_bias   = DS'(curB);
        bus1.relu_en   = 1'b0;
        bus1.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        totalCnt++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
            $display("[TB] FAIL reset_mid.state: got v%b r%b expected v0 r1", bus1.out_valid, bus1.in_ready);
        else passCnt++;
        repeat (12) @(posedge clk);
        #1;
        totalCnt++;
        if (bus1.out_valid !== 1'b0) $display("[TB] FAIL reset_mid.no_output: got %b expected 0", bus1.out_valid);
        else passCnt++;
        clearOps();
        curD[0] = 64;
        curW[0] = 32;
        curB    = 16;
        exp = model(0);
        runWindow1(0, d, s, lat);
        totalCnt++;
        if (d !== exp[DS-1:0] || s !== exp[DS] || lat != 10)
            $display("[TB] FAIL reset_mid.next: got %0d/%b lat %0d expected %0d/%b lat 10", $signed(d), s, lat, $signed(exp[DS-1:0]), exp[DS]);
        else passCnt++;
        releaseOut1();
    endtask

    task automatic test_lanes3();
        logic [DS:0] exp;
        logic [DS:0] expQ[$];
        int acceptCyc[$];
        int lat;
        int results;
        int relu;
        bit pending;
        clearOps();
        curD[0] = 64;
        curW[0] = 32;
        curB    = 16;
        exp = model(0);
        @(negedge clk);
        bus3.in_data   = packArr(curD);
        bus3.in_weight = packArr(curW);
        bus3.in_bias   = DS'(curB);
        bus3.relu_en   = 1'b0;
        bus3.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus3.out_valid) begin
                lat = c;
                break;
            end
        end
        totalCnt++;
        if (bus3.out_data !== exp[DS-1:0] || bus3.out_sat !== exp[DS] || lat != 4)
            $display("[TB] FAIL lanes3.single: got %0d/%b lat %0d expected %0d/%b lat 4",
                     $signed(bus3.out_data), bus3.out_sat, lat, $signed(exp[DS-1:0]), exp[DS]);
        else passCnt++;
        @(negedge clk);
        bus3.out_ready = 1'b1;
        @(posedge clk);
        // Back-to-back windows with the consumer always ready
        pending = 1'b1;
        results = 0;
        relu    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (pending) begin
                randomOps();
                relu = int'($urandom_range(1));
                bus3.in_data   = packArr(curD);
                bus3.in_weight = packArr(curW);
                bus3.in_bias   = DS'(curB);
                bus3.relu_en   = (relu != 0);
                bus3.in_valid  = 1'b1;
                pending = 1'b0;
            end
            if (bus3.out_valid) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1AA;
                totalCnt++;
                if (bus3.out_data !== exp[DS-1:0] || bus3.out_sat !== exp[DS])
                    $display("[TB] FAIL lanes3.b2b_result%0d: got %0d/%b expected %0d/%b", results,
                             $signed(bus3.out_data), bus3.out_sat, $signed(exp[DS-1:0]), exp[DS]);
                else passCnt++;
                results++;
            end
            if (bus3.in_ready) begin
                acceptCyc.push_back(cyc);
                expQ.push_back(model(relu));
                pending = 1'b1;
            end
            @(posedge clk);
        end
        bus3.in_valid  = 1'b0;
        totalCnt++;
        if (results < 5) $display("[TB] FAIL lanes3.b2b_count: got %0d results expected at least 5", results);
        else passCnt++;
        for (int i = 1; i < acceptCyc.size(); i++) begin
            totalCnt++;
            if (acceptCyc[i] - acceptCyc[i-1] != 6)
                $display("[TB] FAIL lanes3.b2b_interval%0d: got %0d cycles expected 6", i, acceptCyc[i] - acceptCyc[i-1]);
            else passCnt++;
        end
        repeat (8) @(posedge clk);
        bus3.out_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.in_weight = '0;
        bus1.in_bias   = '0;
        bus1.relu_en   = 1'b0;
        bus1.out_ready = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.in_data   = '0;
        bus3.in_weight = '0;
        bus3.in_bias   = '0;
        bus3.relu_en   = 1'b0;
        bus3.out_ready = 1'b0;

        test_reset();
        test_single();
        test_negative();
        test_round_sat();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_lanes3();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mac_window_seq.md
Name: mac_window_seq

Overview:
- Sequential, parametrised successor to the combinational window multiply-accumulate used in the conv layers.
- Accepts one KERNEL_SIZE window of signed fixed-point activations, weights and a bias per handshake.
- Accumulates LANES products per cycle, then adds the bias, rounds, saturates and optionally applies ReLU.
- Sits between the line-buffer/window generator and the feature-map writer in the VGG16 conv datapath.

Parameters:
- DATA_SIZE, 8, bit width of activation, weight, bias and output (two's complement).
- FRAC_BITS, 6, fractional bits of every DATA_SIZE operand; legal range 0..DATA_SIZE-1.
- KERNEL_SIZE, 9, elements per window (3x3).
- LANES, 1, products accumulated per cycle; must divide KERNEL_SIZE.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  window operands valid.
- in_ready  out  1  block can accept a window.
- in_data  in  DATA_SIZE*KERNEL_SIZE  activations; element 0 in the MS slice.
- in_weight  in  DATA_SIZE*KERNEL_SIZE  weights, same ordering.
- in_bias  in  DATA_SIZE  bias, same Q format.
- relu_en  in  1  apply ReLU to this window; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_SIZE  result.
- out_sat  out  1  the result was clipped by saturation.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state IDLE; out_valid=0; out_data=0; out_sat=0; accumulator=0; index=0. in_ready=1 in the cycle after reset releases.
- Reset mid-operation: rst_n low in any state aborts that window with no output. The next cycle is IDLE.
- FSM overview: four states, IDLE, MAC, FINAL, DONE. in_ready = (state==IDLE), combinational from state.
- IDLE: on in_valid&&in_ready, register data, weight, bias and relu_en; clear acc and idx; go to MAC. Operands are held internally, so the inputs may change after accept.
- MAC: acc += sum of the LANES products for elements idx*LANES .. idx*LANES+LANES-1, then idx++. After the last group (idx==KERNEL_SIZE/LANES-1), go to FINAL.
- FINAL:
  - sum = acc + (bias sign-extended, <<FRAC_BITS).
  - Round half-up: add 1<<(FRAC_BITS-1) when FRAC_BITS>0, then arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]; out_sat=1 if clipped.
  - If relu_en, a negative result becomes 0 (out_sat unchanged).
  - Register out_data and out_sat, set out_valid=1, go to DONE.
- DONE: hold out_data, out_sat and out_valid stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE.
- Handshake limits: no accept in DONE, even with a simultaneous out_ready. One window is in flight at a time.
- Latency: accept edge E0, MAC at E1..EN with N=KERNEL_SIZE/LANES, out_valid high after edge E(N+1). Defaults give 10 cycles; LANES=3 gives 4. Throughput is one window per N+3 cycles with out_ready held high.
- Widths:
  - products are signed 2*DATA_SIZE with 2*FRAC_BITS fractional bits;
  - ACC_W = 2*DATA_SIZE + clog2(KERNEL_SIZE) + 1, so the accumulator never overflows;
  - shifts are arithmetic.
- in_valid is ignored outside IDLE. X on in_data is tolerated when in_valid=0.

Decomposition:
- Shared package mac_pkg:
  - DATA_SIZE/FRAC_BITS defaults and an ACC_W function;
  - state enum {IDLE, MAC, FINAL, DONE};
  - saturation min/max constants.
- One sub-module, mac_round_sat: combinational bias-add, round, saturate and ReLU stage used in FINAL. It is reusable by the FC layer.
- The LANES product tree stays inline.

Test Plan:
All cases use defaults (DATA_SIZE=8, FRAC_BITS=6, KERNEL_SIZE=9, LANES=1) unless noted.
1. Single-element case: element 0 data=64 (1.0), weight=32 (0.5), all others 0, bias=16, relu_en=0 -> out_data=48, out_sat=0, out_valid 10 cycles after accept.
2. Negative result: element 0 data=-64, weight=32, bias=0 -> relu_en=0 gives out_data=0xE0 (-32); relu_en=1 gives out_data=0; out_sat=0 in both.
3. Rounding and saturation:
   - element 0 data=1, weight=32 -> out_data=1 (half-up).
   - all data=64, weights=64 -> out_data=127, out_sat=1.
   - all data=64, weights=-64 -> out_data=-128, out_sat=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid held high with new operands -> out_data stable, in_ready=0, no second accept; after the out_ready handshake, in_ready=1 the next cycle.
5. Reset mid-MAC: rst_n=0 for one cycle at the 3rd MAC cycle -> next cycle out_valid=0, in_ready=1. A following window (test 1 operands) returns 48.
6. Wider configuration, LANES=3: test 1 operands -> out_data=48 with out_valid 4 cycles after accept. Back-to-back windows with out_ready=1 are accepted every 6 cycles.
